// File: rtl/tetris_pkg.sv
// Playfield constants shared by the VRAM writer, color mapper and line scanner,
// plus the scanner state encoding.
package tetris_pkg;

  localparam int          ROWS     = 20;
  localparam int          COLS     = 10;
  localparam logic [15:0] BG_COLOR = 16'h0f05;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } scan_state_t;

endpackage

// File: rtl/line_scanner_if.sv
// Row-read bus between the line scanner (master) and the VRAM writer stage (slave).
interface line_scanner_if #(
  parameter int COLS = tetris_pkg::COLS
);
  // Handshake: master pulses row_ld for one cycle with row valid; the slave later
  // pulses row_ready once, and read_reg then holds that row until the next row_ld.
  // There is no back-pressure: a row_ready seen outside a pending request is dropped.
  logic                  row_ld;
  logic [7:0]            row;
  logic                  row_ready;
  logic [COLS-1:0][15:0] read_reg;

  modport master (output row_ld, output row, input row_ready, input read_reg);
  modport slave  (input row_ld, input row, output row_ready, output read_reg);

endinterface

// File: rtl/line_scanner_row_full_detect.sv
// Classifies one captured row: full when no cell is background, empty when every
// cell is background.
module row_full_detect
  import tetris_pkg::*;
#(
  parameter int COLS_P = COLS
) (
  input  logic [COLS_P-1:0][15:0] read_reg,
  input  logic [15:0]             bg_color,
  output logic                    row_full,
  output logic                    row_empty
);

  always_comb begin
    row_full  = 1'b1;
    row_empty = 1'b1;
    for (int c = 0; c < COLS_P; c++) begin
      if (read_reg[c] == bg_color) row_full  = 1'b0;
      else                         row_empty = 1'b0;
    end
  end

endmodule

// File: rtl/line_scanner.sv
// Bottom-up playfield scan after a piece locks: requests each row over the row-read
// bus, classifies it, and accumulates the full-row bitmap and line counts.
module line_scanner #(
  parameter int          ROWS       = tetris_pkg::ROWS,
  parameter int          COLS       = tetris_pkg::COLS,
  parameter logic [15:0] BG_COLOR   = tetris_pkg::BG_COLOR,
  parameter int          TIMEOUT    = 1024,
  parameter int          MAX_RETRY  = 3,
  parameter int          EARLY_EXIT = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  line_scanner_if.master          bus,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [ROWS-1:0]         full_rows,
  output logic [4:0]              lines_cleared,
  output logic [15:0]             total_lines,
  output tetris_pkg::scan_state_t dbg_state
);
  import tetris_pkg::*;

  localparam int            WW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int            RW         = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
  localparam logic [7:0]    ROW_FIRST  = 8'(ROWS - 1);
  localparam logic [ROWS-1:0] ROW_ONE  = {{(ROWS-1){1'b0}}, 1'b1};

  scan_state_t     state_q, state_d;
  logic [7:0]      row_q, row_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            row_ld_q, row_ld_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            row_empty_q, row_empty_d;
  logic [ROWS-1:0] full_rows_q, full_rows_d;
  logic [4:0]      lines_q, lines_d;
  logic [15:0]     total_lines_q, total_lines_d;

  logic            row_full, row_empty;
  logic [16:0]     total_sum;

  row_full_detect #(.COLS_P(COLS)) u_detect (
    .read_reg  (bus.read_reg),
    .bg_color  (BG_COLOR),
    .row_full  (row_full),
    .row_empty (row_empty)
  );

  // Widened add so a carry out clamps instead of wrapping.
  assign total_sum = {1'b0, total_lines_q} + 17'(lines_q);

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    retry_d       = retry_q;
    wait_d        = wait_q;
    row_ld_d      = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;
    error_d       = error_q;
    row_empty_d   = row_empty_q;
    full_rows_d   = full_rows_q;
    lines_d       = lines_q;
    total_lines_d = total_lines_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          full_rows_d = '0;
          lines_d     = '0;
          error_d     = 1'b0;
          row_d       = ROW_FIRST;
          retry_d     = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        row_ld_d = 1'b1;
        busy_d   = 1'b1;
        wait_d   = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        if (bus.row_ready) begin
          state_d = CHECK;
        end else if (wait_q == WAIT_LAST) begin
          if (retry_q == RETRY_LAST) begin
            error_d = 1'b1;
            state_d = DONE;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = REQ;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      CHECK: begin
        if (row_full) begin
          full_rows_d = full_rows_q | (ROW_ONE << row_q);
          lines_d     = lines_q + 5'd1;
        end
        row_empty_d = row_empty;
        retry_d     = '0;
        state_d     = NEXT;
      end
      NEXT: begin
        if (row_q == 8'd0 || (EARLY_EXIT != 0 && row_empty_q)) begin
          state_d = DONE;
        end else begin
          row_d   = row_q - 8'd1;
          state_d = REQ;
        end
      end
      DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        if (!error_q) total_lines_d = total_sum[16] ? 16'hFFFF : total_sum[15:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      row_q         <= '0;
      retry_q       <= '0;
      wait_q        <= '0;
      row_ld_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      row_empty_q   <= 1'b0;
      full_rows_q   <= '0;
      lines_q       <= '0;
      total_lines_q <= '0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      retry_q       <= retry_d;
      wait_q        <= wait_d;
      row_ld_q      <= row_ld_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      row_empty_q   <= row_empty_d;
      full_rows_q   <= full_rows_d;
      lines_q       <= lines_d;
      total_lines_q <= total_lines_d;
    end
  end

  assign bus.row_ld    = row_ld_q;
  assign bus.row       = row_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign full_rows     = full_rows_q;
  assign lines_cleared = lines_q;
  assign total_lines   = total_lines_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_line_scanner.sv
// Bench for line_scanner: two instances (early exit on and off) share one row-read
// responder; a row-level reference model predicts the request sequence and results.
`timescale 1ns/1ps
module tb_line_scanner;
  import tetris_pkg::*;

  localparam int TIMEOUT   = 1024;
  localparam int MAX_RETRY = 3;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT wiring ----------------
  logic                  start_a = 1'b0, start_b = 1'b0, sel = 1'b0;
  logic                  row_ready = 1'b0;
  logic [COLS-1:0][15:0] read_reg = '0;

  line_scanner_if bus_a ();
  line_scanner_if bus_b ();
  assign bus_a.row_ready = row_ready;
  assign bus_b.row_ready = row_ready;
  assign bus_a.read_reg  = read_reg;
  assign bus_b.read_reg  = read_reg;

  logic busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [ROWS-1:0] full_a, full_b;
  logic [4:0]      lines_a, lines_b;
  logic [15:0]     tot_a, tot_b;
  scan_state_t     st_a, st_b;

  line_scanner #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .EARLY_EXIT(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .bus(bus_a), .busy(busy_a),
    .done(done_a), .error(err_a), .full_rows(full_a), .lines_cleared(lines_a),
    .total_lines(tot_a), .dbg_state(st_a));

  line_scanner #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .EARLY_EXIT(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .bus(bus_b), .busy(busy_b),
    .done(done_b), .error(err_b), .full_rows(full_b), .lines_cleared(lines_b),
    .total_lines(tot_b), .dbg_state(st_b));

  logic            m_row_ld, m_busy, m_done, m_err;
  logic [7:0]      m_row;
  logic [ROWS-1:0] m_full;
  logic [4:0]      m_lines;
  logic [15:0]     m_tot;
  assign m_row_ld = sel ? bus_b.row_ld : bus_a.row_ld;
  assign m_row    = sel ? bus_b.row    : bus_a.row;
  assign m_busy   = sel ? busy_b  : busy_a;
  assign m_done   = sel ? done_b  : done_a;
  assign m_err    = sel ? err_b   : err_a;
  assign m_full   = sel ? full_b  : full_a;
  assign m_lines  = sel ? lines_b : lines_a;
  assign m_tot    = sel ? tot_b   : tot_a;

  // ---------------- scoreboard state ----------------
  int total_n = 0;
  int bad_n   = 0;
  logic [7:0]      exp_q[$];
  int              ld_cyc[$];
  logic [ROWS-1:0] exp_full[2];
  logic [4:0]      exp_lines[2];
  logic            exp_err[2];
  logic [15:0]     exp_tot[2];
  logic [COLS-1:0][15:0] vram [ROWS];

  bit scan_active = 1'b0, done_seen = 1'b0, dup_en = 1'b0, drop_pending = 1'b0;
  int scan_cyc = 0;
  int mode = 0;
  int rsp_lat;
  logic [7:0] rsp_row;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Walks rows bottom-up from the playfield contents and the responder behaviour.
  task automatic model_scan(input int inst, input int m);
    logic [ROWS-1:0] f;
    int n;
    int t;
    bit err, is_full, is_empty;
    f = '0; n = 0; err = 1'b0;
    exp_q.delete();
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (m == 2) begin
        for (int k = 0; k <= MAX_RETRY; k++) exp_q.push_back(8'(r));
        err = 1'b1;
        break;
      end
      if (m == 1 && r == ROWS - 1) exp_q.push_back(8'(r));
      exp_q.push_back(8'(r));
      is_full = 1'b1;
      is_empty = 1'b1;
      for (int c = 0; c < COLS; c++) begin
        if (vram[r][c] == BG_COLOR) is_full = 1'b0;
        else is_empty = 1'b0;
      end
      if (is_full) begin
        f[r] = 1'b1;
        n++;
      end
      if (inst == 0 && is_empty) break;
    end
    exp_full[inst]  = f;
    exp_lines[inst] = 5'(n);
    exp_err[inst]   = err;
    if (!err) begin
      t = int'(exp_tot[inst]) + n;
      exp_tot[inst] = (t > 65535) ? 16'hFFFF : 16'(t);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      exp_full[i] = '0; exp_lines[i] = '0; exp_err[i] = 1'b0; exp_tot[i] = '0;
    end
    exp_q.delete();
    scan_active = 1'b0;
  endtask

  // ---------------- row-read responder ----------------
  always begin : responder
    @(negedge clk);
    if (reset_n && m_row_ld) begin
      rsp_row = m_row;
      if (mode == 1 && drop_pending) begin
        drop_pending = 1'b0;
      end else if (mode != 2) begin
        rsp_lat = $urandom_range(0, 4);
        repeat (rsp_lat) @(negedge clk);
        read_reg  = vram[int'(rsp_row)];
        row_ready = 1'b1;
        @(negedge clk);
        if (dup_en) @(negedge clk);
        row_ready = 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin : compare
    logic [7:0] r;
    if (reset_n) begin
      if (scan_active) begin
        scan_cyc++;
        if (scan_cyc == 1) check("busy_early", m_busy, 0);
        else if (m_done)   check("busy_at_done", m_busy, 0);
        else               check("busy_mid", m_busy, 1);
        if (scan_cyc == 2) check("first_req", m_row_ld, 1);
        if (m_row_ld) begin
          ld_cyc.push_back(scan_cyc);
          check("row_ld_pending", (exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            check("row_ld_row", m_row, r);
          end
        end
        if (m_done) begin
          check("queue_drained", exp_q.size(), 0);
          check("done_full", m_full, exp_full[sel]);
          check("done_lines", m_lines, exp_lines[sel]);
          check("done_err", m_err, exp_err[sel]);
          check("done_total", m_tot, exp_tot[sel]);
          scan_active = 1'b0;
          done_seen = 1'b1;
        end
      end else begin
        check("idle_busy", m_busy, 0);
        check("idle_done", m_done, 0);
        check("idle_row_ld", m_row_ld, 0);
        check("hold_full", m_full, exp_full[sel]);
        check("hold_lines", m_lines, exp_lines[sel]);
        check("hold_err", m_err, exp_err[sel]);
        check("hold_total", m_tot, exp_tot[sel]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    reset_n = 1'b0;
    row_ready = 1'b0;
    mode = 0;
    clear_model();
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic fill_row(input int r, input int kind);
    logic [15:0] v;
    int hole;
    hole = $urandom_range(0, COLS - 1);
    for (int c = 0; c < COLS; c++) begin
      v = 16'($urandom);
      if (v == BG_COLOR) v = 16'h1234;
      if (kind == 1 || (kind == 2 && c == hole)) v = BG_COLOR;
      vram[r][c] = v;
    end
  endtask

  task automatic begin_scan(input int inst, input int m, input bit dup);
    @(negedge clk); #1;
    sel = (inst != 0);
    mode = m;
    dup_en = dup;
    drop_pending = (m == 1);
    model_scan(inst, m);
    ld_cyc.delete();
    scan_cyc = 0;
    done_seen = 1'b0;
    scan_active = 1'b1;
    if (inst == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic run_scan(input int inst, input int m, input bit dup, input int poke);
    begin_scan(inst, m, dup);
    for (int i = 0; i < 6000 && !done_seen; i++) begin
      @(negedge clk);
      if (i == poke) begin
        #1;
        if (inst == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
      end
    end
    @(negedge clk);
    check("done_timeout", done_seen, 1);
    if (!done_seen) apply_reset();
  endtask

  task automatic set_pattern2();
    for (int r = 0; r < ROWS; r++) fill_row(r, $urandom_range(0, 2));
    fill_row(19, 0);
    fill_row(18, 0);
    fill_row(17, 2);
    fill_row(16, 0);
    fill_row(15, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    clear_model();
    for (int r = 0; r < ROWS; r++) fill_row(r, 1);
    repeat (3) @(negedge clk);
    #1;
    check("rst_state_a", st_a, IDLE);
    check("rst_state_b", st_b, IDLE);
    check("rst_row_ld", bus_a.row_ld, 0);
    check("rst_row", bus_a.row, 0);
    check("rst_total_b", tot_b, 0);
    reset_n = 1'b1;

    // All background, early exit: one request for the bottom row.
    run_scan(0, 0, 1'b0, -1);
    check("t1_ld_count", ld_cyc.size(), 1);
    check("t1_full", m_full, 20'h0);
    check("t1_lines", m_lines, 0);
    check("t1_err", m_err, 0);

    // Rows 19,18,16 full, 17 partial, 15 empty; duplicate row_ready pulses.
    set_pattern2();
    run_scan(0, 0, 1'b1, -1);
    check("t2_ld_count", ld_cyc.size(), 5);
    check("t2_full", m_full, 20'hD0000);
    check("t2_lines", m_lines, 3);
    check("t2_total", m_tot, 3);

    // No early exit, every row full, twice.
    for (int r = 0; r < ROWS; r++) fill_row(r, 0);
    run_scan(1, 0, 1'b0, -1);
    check("t3_ld_count", ld_cyc.size(), 20);
    check("t3_full", m_full, 20'hFFFFF);
    check("t3_lines", m_lines, 20);
    run_scan(1, 0, 1'b0, -1);
    check("t3_total", m_tot, 40);

    // First request for row 19 dropped.
    set_pattern2();
    run_scan(0, 1, 1'b0, -1);
    if (ld_cyc.size() >= 2) check("t4_retry_gap", ld_cyc[1] - ld_cyc[0], TIMEOUT + 1);
    else check("t4_retry_count", ld_cyc.size(), 2);
    check("t4_err", m_err, 0);
    check("t4_total", m_tot, 6);

    // Responder silent; a start pulse mid-scan must not restart it.
    run_scan(0, 2, 1'b0, 500);
    check("t5_ld_count", ld_cyc.size(), MAX_RETRY + 1);
    for (int k = 1; k < ld_cyc.size(); k++)
      check("t5_retry_gap", ld_cyc[k] - ld_cyc[k-1], TIMEOUT + 1);
    check("t5_err", m_err, 1);
    check("t5_total", m_tot, 6);

    // Randomized playfields on both instances.
    for (int k = 0; k < 10; k++) begin
      for (int r = 0; r < ROWS; r++) fill_row(r, $urandom_range(0, 4) % 3);
      run_scan($urandom_range(0, 1), 0, 1'($urandom_range(0, 1)), -1);
    end

    // Reset asserted while waiting for a row.
    set_pattern2();
    run_scan(0, 0, 1'b0, -1);
    begin_scan(0, 2, 1'b0);
    repeat (40) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_row_ld", bus_a.row_ld, 0);
    check("rst_mid_row", bus_a.row, 0);
    check("rst_mid_busy", busy_a, 0);
    check("rst_mid_done", done_a, 0);
    check("rst_mid_err", err_a, 0);
    check("rst_mid_full", full_a, 0);
    check("rst_mid_lines", lines_a, 0);
    check("rst_mid_total", tot_a, 0);
    check("rst_mid_state", st_a, IDLE);
    mode = 0;
    clear_model();
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;

    // Saturation of the running total.
    @(negedge clk); #1;
    sel = 1'b0;
    force dut_a.total_lines_q = 16'hFFFE;
    exp_tot[0] = 16'hFFFE;
    @(posedge clk); #1;
    release dut_a.total_lines_q;
    set_pattern2();
    run_scan(0, 0, 1'b0, -1);
    check("t8_total_sat", m_tot, 16'hFFFF);
    run_scan(0, 0, 1'b0, -1);
    check("t8_total_hold", m_tot, 16'hFFFF);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
